// File: rtl/reg_cmd_initiator.sv
// reg_cmd_initiator: serialises one register request into an 8-byte command frame and collects the 4-byte reply
module reg_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_timeout,
    output logic [7:0]  cmd_out,
    output logic        cmd_wr,
    input  logic        cmd_full,
    input  logic [7:0]  reply_in,
    input  logic        reply_rdy,
    output logic        reply_ack,
    input  logic        reply_end
);
    typedef enum logic [1:0] {IDLE, TX, RX, DONE} state_t;
    state_t      state, state_d;
    logic [2:0]  idx;
    logic [15:0] tcnt;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [63:0] frame;
    logic        tmo_hit;
    assign frame   = {wdata_q, addr_q, 7'b0, wr_q, 8'hAA};
    assign tmo_hit = tcnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        state <= reset_n ? state_d : IDLE;
    always_comb begin
        state_d    = state;
        req_ready  = reset_n && state == IDLE;
        reply_ack  = reset_n && state == RX && reply_rdy;
        resp_valid = state == DONE;
        case (state)
            IDLE:    state_d = req_valid ? TX : IDLE;
            TX:      state_d = (!cmd_full && idx == 3'd7) ? RX : TX;
            RX:      state_d = (reply_ack ? (reply_end || idx == 3'd3) : tmo_hit) ? DONE : RX;
            default: state_d = resp_ready ? IDLE : DONE;
        endcase
    end
    // the idle counter restarts on entry to RX (last TX byte) and on every reply byte
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_wr       <= 1'b0;
            cmd_out      <= 8'h00;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
            idx          <= 3'd0;
            tcnt         <= 16'd0;
            wr_q         <= 1'b0;
            addr_q       <= 16'h0;
            wdata_q      <= 32'h0;
        end else begin
            cmd_wr <= 1'b0;
            if (state == IDLE && req_valid) begin
                wr_q         <= req_wr;
                addr_q       <= req_addr;
                wdata_q      <= req_wr ? req_wdata : 32'h0;
                resp_rdata   <= 32'h0;
                resp_err     <= 1'b0;
                resp_timeout <= 1'b0;
                idx          <= 3'd0;
            end
            if (state == TX && !cmd_full) begin
                cmd_out <= frame[{idx, 3'b000} +: 8];
                cmd_wr  <= 1'b1;
                idx     <= idx + 3'd1;
                tcnt    <= 16'd0;
            end
            if (reply_ack) begin
                resp_rdata[{idx[1:0], 3'b000} +: 8] <= reply_in;
                resp_err <= reply_end ? idx != 3'd3 : idx == 3'd3;
                idx      <= idx + 3'd1;
                tcnt     <= 16'd0;
            end else if (state == RX) begin
                tcnt <= tcnt + 16'd1;
                if (tmo_hit) begin
                    resp_err     <= 1'b1;
                    resp_timeout <= 1'b1;
                    resp_rdata   <= 32'h0;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_cmd_initiator.sv
// tb_reg_cmd_initiator: directed self-checking bench for reg_cmd_initiator
module tb_reg_cmd_initiator;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid, resp_ready = 1'b0, resp_err, resp_timeout;
    logic [31:0] resp_rdata;
    logic [7:0]  cmd_out;
    logic        cmd_wr, cmd_full = 1'b0;
    logic [7:0]  reply_in = 8'h0;
    logic        reply_rdy = 1'b0, reply_ack, reply_end = 1'b0;
    int          n_run = 0, n_fail = 0;
    logic [7:0]  cap[$];

    reg_cmd_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_timeout(resp_timeout),
        .cmd_out(cmd_out), .cmd_wr(cmd_wr), .cmd_full(cmd_full),
        .reply_in(reply_in), .reply_rdy(reply_rdy), .reply_ack(reply_ack), .reply_end(reply_end)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_wr) cap.push_back(cmd_out);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic wr, input logic [15:0] addr, input logic [31:0] data);
        int k = 0;
        while (!req_ready && k < 50) begin tick(); k++; end
        chk("req_ready_wait", {63'b0, req_ready}, 64'd1);
        cap.delete();
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data;
        tick();
        req_valid = 1'b0;
        chk("req_ready_busy", {63'b0, req_ready}, 64'd0);
    endtask

    task automatic wait_frame(input string tag, input logic [63:0] exp);
        int k = 0;
        logic [63:0] f = 64'h0;
        while (cap.size() < 8 && k < 60) begin tick(); k++; end
        chk({tag, "_len"}, 64'(cap.size()), 64'd8);
        for (int i = 0; i < 8 && i < cap.size(); i++) f[8*i +: 8] = cap[i];
        chk(tag, f, exp);
    endtask

    task automatic reply(input logic [31:0] b, input int n, input int end_at);
        for (int i = 0; i < n; i++) begin
            reply_rdy = 1'b1; reply_in = b[8*i +: 8]; reply_end = (i == end_at);
            #1;
            chk("reply_ack", {63'b0, reply_ack}, 64'd1);
            tick();
        end
        reply_rdy = 1'b0; reply_end = 1'b0;
    endtask

    task automatic take_resp(input string tag, input logic [31:0] rd, input logic err, input logic tmo);
        int k = 0;
        while (!resp_valid && k < 60) begin tick(); k++; end
        chk({tag, "_valid"}, {63'b0, resp_valid}, 64'd1);
        chk({tag, "_rdata"}, {32'b0, resp_rdata}, {32'b0, rd});
        chk({tag, "_err"}, {62'b0, resp_err, resp_timeout}, {62'b0, err, tmo});
        chk({tag, "_noreq"}, {63'b0, req_ready}, 64'd0);
        tick();
        chk({tag, "_hold"}, {31'b0, resp_valid, resp_rdata}, {31'b0, 1'b1, rd});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_release"}, {62'b0, resp_valid, req_ready}, 64'b01);
    endtask

    initial begin
        int k;
        reply_rdy = 1'b1;
        tick(); tick();
        chk("rst_outputs", {resp_valid, resp_err, resp_timeout, cmd_wr, cmd_out, resp_rdata},
            {4'b0, 8'h00, 32'h0});
        chk("rst_handshake", {62'b0, req_ready, reply_ack}, 64'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_ready", {62'b0, req_ready, reply_ack}, 64'b10);
        reply_rdy = 1'b0;

        send_req(1'b1, 16'h1234, 32'hDEADBEEF);
        chk("first_byte_gap", {63'b0, cmd_wr}, 64'd0);
        tick();
        chk("first_byte", {55'b0, cmd_wr, cmd_out}, {55'b0, 1'b1, 8'hAA});
        reply_rdy = 1'b1;
        #1 chk("ack_in_tx", {63'b0, reply_ack}, 64'd0);
        reply_rdy = 1'b0;
        wait_frame("wr_frame", 64'hDEADBEEF_1234_01AA);
        reply(32'hDEADBEEF, 4, 3);
        take_resp("wr", 32'hDEADBEEF, 1'b0, 1'b0);

        send_req(1'b0, 16'h0002, 32'hCAFEF00D);
        tick(); tick(); tick();
        chk("pre_stall_bytes", 64'(cap.size()), 64'd2);
        cmd_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_wr", {63'b0, cmd_wr}, 64'd0);
        end
        cmd_full = 1'b0;
        wait_frame("rd_frame", 64'h00000000_0002_00AA);
        reply(32'h12345678, 4, 3);
        take_resp("rd", 32'h12345678, 1'b0, 1'b0);

        send_req(1'b0, 16'h00A5, 32'h0);
        wait_frame("to_frame", 64'h00000000_00A5_00AA);
        reply(32'h0000BBAA, 2, 9);
        k = 0;
        while (!resp_valid && k < 100) begin tick(); k++; end
        chk("timeout_cycles", 64'(k), 64'd16);
        take_resp("to", 32'h0, 1'b1, 1'b1);

        send_req(1'b1, 16'h0010, 32'h01020304);
        wait_frame("early_frame", 64'h01020304_0010_01AA);
        reply(32'h00002211, 2, 1);
        take_resp("early", 32'h00002211, 1'b1, 1'b0);

        send_req(1'b1, 16'h0003, 32'h55667788);
        tick(); tick(); tick(); tick();
        reset_n = 1'b0;
        reply_rdy = 1'b1;
        tick();
        chk("midrst_quiet", {61'b0, cmd_wr, req_ready, reply_ack}, 64'd0);
        tick();
        reset_n = 1'b1;
        reply_rdy = 1'b0;
        tick();
        chk("midrst_aborted", {60'b0, cmd_wr, req_ready, resp_valid, resp_err}, 64'b0100);
        chk("midrst_bytes", 64'(cap.size()), 64'd4);
        send_req(1'b0, 16'hBEEF, 32'hFFFFFFFF);
        wait_frame("clean_frame", 64'h00000000_BEEF_00AA);
        reply(32'hA1B2C3D4, 4, 3);
        take_resp("clean", 32'hA1B2C3D4, 1'b0, 1'b0);
        chk("clean_no_extra", 64'(cap.size()), 64'd8);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
